// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the FFT core.
//   twiddle_t  - Q1.15 twiddle component type (default twiddle width)
//   tw_state_e - twiddle generator sequencing states
//   cos_q      - quantised, saturated quarter-wave cosine entry, evaluated
//                at elaboration to build the twiddle ROM contents
package fft_pkg;

  localparam int TW_WIDTH = 16;
  localparam real PI = 3.14159265358979323846;

  typedef logic signed [TW_WIDTH-1:0] twiddle_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tw_state_e;

  // round(cos(2*pi*i/n) * 2^(width-1)), round half away from zero, with the
  // +1.0 entry clamped to the largest positive code.
  function automatic int cos_q(input int i, input int n, input int width);
    real v;
    int  m;
    int  lim;
    v   = $cos(2.0 * PI * real'(i) / real'(n)) * (2.0 ** (width - 1));
    lim = (1 << (width - 1)) - 1;
    if (v >= 0.0) m = $rtoi(v + 0.5);
    else          m = -$rtoi(-v + 0.5);
    if (m > lim)  m = lim;
    if (m < -lim) m = -lim;
    return m;
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// twiddle_qrom: quarter-wave cosine ROM, Q+1 entries (Q = N_MAX/4), with two
// synchronous read ports. One port reads C[addr], the other C[Q-addr], so the
// sine term is available in the same cycle. Read data is not reset.
//   clk   - clock
//   en    - read enable (pipeline advance)
//   addr  - table index, 0..Q
//   c_a   - C[addr], registered
//   c_qa  - C[Q-addr], registered
module twiddle_qrom
  import fft_pkg::*;
#(
  parameter int N_MAX = 1024,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(N_MAX) - 1
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [AW-1:0]           addr,
  output logic signed [WIDTH-1:0] c_a,
  output logic signed [WIDTH-1:0] c_qa
);

  localparam int Q = N_MAX / 4;

  logic signed [WIDTH-1:0] rom [0:Q];
  logic [AW-1:0]           addr_q;

  for (genvar gi = 0; gi <= Q; gi++) begin : g_rom
    assign rom[gi] = WIDTH'(cos_q(gi, N_MAX, WIDTH));
  end

  assign addr_q = AW'(Q) - addr;

  always_ff @(posedge clk) begin
    if (en) begin
      c_a  <= rom[addr];
      c_qa <= rom[addr_q];
    end
  end

endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen: streaming radix-2 twiddle generator.
// On an accepted start, emits the 2^stage twiddles of one butterfly stage,
// W = exp(-/+ j*2*pi*e/N_MAX), e = k * (N_MAX >> (stage+1)), over a
// valid/ready stream. Three pipeline stages: address/flags, ROM read,
// sign application. All stages stall together under back-pressure.
//   clk, rst        - clock, asynchronous active-high reset
//   start           - request; taken only when busy=0
//   log2n, stage    - transform size and butterfly stage, sampled on start
//   inverse         - conjugate output, sampled on start
//   busy            - sequence in flight
//   err             - one-cycle pulse for an illegal request
//   tw_valid/ready  - output handshake
//   tw_re, tw_im    - twiddle components, signed Q1.(WIDTH-1)
//   tw_last         - marks the final twiddle of the stage
module twiddle_gen
  import fft_pkg::*;
#(
  parameter  int N_MAX     = 1024,
  parameter  int WIDTH     = 16,
  localparam int LOG2_NMAX = $clog2(N_MAX)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [$clog2(LOG2_NMAX+1)-1:0]     log2n,
  input  logic [$clog2(LOG2_NMAX+1)-1:0]     stage,
  input  logic                               inverse,
  output logic                               busy,
  output logic                               err,
  output logic                               tw_valid,
  input  logic                               tw_ready,
  output logic signed [WIDTH-1:0]            tw_re,
  output logic signed [WIDTH-1:0]            tw_im,
  output logic                               tw_last
);

  localparam int LW = $clog2(LOG2_NMAX + 1);
  // Exponents stay below N_MAX/2, so EW bits cover both e and k.
  localparam int EW = LOG2_NMAX - 1;

  tw_state_e state_reg, state_next;
  logic [EW-1:0] k_reg, k_next;
  logic [EW-1:0] last_reg, last_next;
  logic [LW-1:0] shamt_reg, shamt_next;
  logic          inv_reg, inv_next;
  logic          err_reg, err_next;

  logic          legal;
  logic          en;
  logic          issue;
  logic [EW-1:0] issue_k;
  logic          issue_inv;
  logic          issue_last;
  logic [EW-1:0] e;

  // P1: table address and flags
  logic          p1_valid, p1_quad, p1_inv, p1_last;
  logic [EW-1:0] p1_a;
  // P2: ROM data (inside twiddle_qrom) plus flags
  logic          p2_valid, p2_quad, p2_inv, p2_last;
  logic signed [WIDTH-1:0] c_a, c_qa;
  // P3: output registers
  logic                    tw_valid_reg, tw_last_reg;
  logic signed [WIDTH-1:0] re_reg, im_reg, re_next, im_next;

  assign legal = (log2n != '0) && (int'(log2n) <= LOG2_NMAX) && (stage < log2n);
  assign en    = !(tw_valid_reg && !tw_ready);
  // stride = 2^(EW - stage); k < 2^stage keeps e below N_MAX/2.
  assign e     = issue_k << shamt_reg;

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    last_next  = last_reg;
    shamt_next = shamt_reg;
    inv_next   = inv_reg;
    err_next   = 1'b0;
    issue      = 1'b0;
    issue_k    = k_reg;
    issue_inv  = inv_reg;
    issue_last = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (legal) begin
            // k=0 is issued in the accept cycle itself (e=0 for any stride).
            issue      = 1'b1;
            issue_k    = '0;
            issue_inv  = inverse;
            issue_last = (stage == '0);
            last_next  = EW'((32'd1 << stage) - 32'd1);
            shamt_next = LW'(EW) - stage;
            inv_next   = inverse;
            k_next     = EW'(1);
            state_next = (stage == '0) ? DRAIN : RUN;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (en) begin
          issue      = 1'b1;
          issue_k    = k_reg;
          issue_last = (k_reg == last_reg);
          k_next     = k_reg + EW'(1);
          if (k_reg == last_reg) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (tw_valid_reg && tw_ready && tw_last_reg) begin
          state_next = IDLE;
          k_next     = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      last_reg  <= '0;
      shamt_reg <= '0;
      inv_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      last_reg  <= last_next;
      shamt_reg <= shamt_next;
      inv_reg   <= inv_next;
      err_reg   <= err_next;
    end
  end

  // P1: split e into quadrant flag and in-quadrant offset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p1_quad  <= 1'b0;
      p1_inv   <= 1'b0;
      p1_last  <= 1'b0;
      p1_a     <= '0;
    end else if (en) begin
      p1_valid <= issue;
      p1_quad  <= e[EW-1];
      p1_inv   <= issue_inv;
      p1_last  <= issue_last;
      p1_a     <= {1'b0, e[EW-2:0]};
    end
  end

  // P2: ROM read alongside the flags.
  twiddle_qrom #(
    .N_MAX (N_MAX),
    .WIDTH (WIDTH),
    .AW    (EW)
  ) u_qrom (
    .clk  (clk),
    .en   (en),
    .addr (p1_a),
    .c_a  (c_a),
    .c_qa (c_qa)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p2_valid <= 1'b0;
      p2_quad  <= 1'b0;
      p2_inv   <= 1'b0;
      p2_last  <= 1'b0;
    end else if (en) begin
      p2_valid <= p1_valid;
      p2_quad  <= p1_quad;
      p2_inv   <= p1_inv;
      p2_last  <= p1_last;
    end
  end

  // P3: quadrant symmetry. First quadrant: (C[a], -C[Q-a]);
  // second: (-C[Q-a], -C[a]). Table entries never reach -2^(WIDTH-1),
  // so negation cannot overflow.
  always_comb begin
    re_next = p2_quad ? -c_qa : c_a;
    im_next = p2_quad ? -c_a : -c_qa;
    if (p2_inv) im_next = -im_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tw_valid_reg <= 1'b0;
      tw_last_reg  <= 1'b0;
      re_reg       <= '0;
      im_reg       <= '0;
    end else if (en) begin
      tw_valid_reg <= p2_valid;
      tw_last_reg  <= p2_valid & p2_last;
      re_reg       <= re_next;
      im_reg       <= im_next;
    end
  end

  assign busy     = (state_reg != IDLE);
  assign err      = err_reg;
  assign tw_valid = tw_valid_reg;
  assign tw_last  = tw_last_reg;
  assign tw_re    = re_reg;
  assign tw_im    = im_reg;

endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: scoreboard bench for twiddle_gen (N_MAX=1024, WIDTH=16).
// Expected words are queued when a request is driven and popped by the
// negedge monitor whenever the DUT presents a word that is being accepted.
module tb_twiddle_gen;
  import fft_pkg::*;

  localparam int N_MAX = 1024;
  localparam int WIDTH = 16;
  localparam int LW    = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [LW-1:0]           log2n;
  logic [LW-1:0]           stage;
  logic                    inverse;
  logic                    busy;
  logic                    err;
  logic                    tw_valid;
  logic                    tw_ready;
  logic signed [WIDTH-1:0] tw_re;
  logic signed [WIDTH-1:0] tw_im;
  logic                    tw_last;

  twiddle_gen #(
    .N_MAX (N_MAX),
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .log2n    (log2n),
    .stage    (stage),
    .inverse  (inverse),
    .busy     (busy),
    .err      (err),
    .tw_valid (tw_valid),
    .tw_ready (tw_ready),
    .tw_re    (tw_re),
    .tw_im    (tw_im),
    .tw_last  (tw_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    bit last;
  } word_t;

  word_t exp_q[$];
  word_t mon_w;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  int    words_seen = 0;
  int    stalls_seen = 0;
  bit    held_valid = 1'b0;
  twiddle_t held_re, held_im;
  logic  held_last;

  // Monitor: stall stability plus scoreboard pop on every accepted word.
  always @(negedge clk) begin
    if (mon_en) begin
      if (held_valid) begin
        checks++;
        if (tw_valid !== 1'b1 || tw_re !== held_re || tw_im !== held_im || tw_last !== held_last) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b re=%0d im=%0d last=%0b, held re=%0d im=%0d last=%0b",
                   tw_valid, tw_re, tw_im, tw_last, held_re, held_im, held_last);
        end
      end
      held_valid = (tw_valid === 1'b1) && !tw_ready;
      if (held_valid) stalls_seen++;
      held_re   = tw_re;
      held_im   = tw_im;
      held_last = tw_last;
      if (tw_valid === 1'b1 && tw_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got re=%0d im=%0d last=%0b, required no word", tw_re, tw_im, tw_last);
        end else begin
          mon_w = exp_q.pop_front();
          if (int'(tw_re) !== mon_w.re || int'(tw_im) !== mon_w.im || tw_last !== mon_w.last) begin
            errors++;
            $display("FAIL word_%0d: got (%0d,%0d,last=%0b) required (%0d,%0d,last=%0b)",
                     words_seen, tw_re, tw_im, tw_last, mon_w.re, mon_w.im, mon_w.last);
          end else begin
            $display("word %0d: re=%0d im=%0d last=%0b", words_seen, tw_re, tw_im, tw_last);
          end
        end
        words_seen++;
      end
    end
  end

  function automatic int qv(input real x);
    real v;
    int  m;
    v = x * 32768.0;
    if (v >= 0.0) m = $rtoi(v + 0.5);
    else          m = -$rtoi(-v + 0.5);
    if (m > 32767)  m = 32767;
    if (m < -32767) m = -32767;
    return m;
  endfunction

  // Golden model straight from exp(-j*2*pi*e/N) (no quadrant folding).
  task automatic push_model(input int s, input bit inv);
    word_t w;
    int    e;
    real   ang;
    for (int k = 0; k < (1 << s); k++) begin
      e      = k * (N_MAX >> (s + 1));
      ang    = 2.0 * PI * real'(e) / real'(N_MAX);
      w.re   = qv($cos(ang));
      w.im   = -qv($sin(ang));
      if (inv) w.im = -w.im;
      w.last = (k == (1 << s) - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l, input int s, input bit inv);
    log2n   = LW'(l);
    stage   = LW'(s);
    inverse = inv;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic drain(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; log2n = '0; stage = '0; inverse = 1'b0; tw_ready = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || tw_valid !== 1'b0 || tw_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%0b err=%0b valid=%0b last=%0b, required all 0", busy, err, tw_valid, tw_last);
    end
    checks++;
    if (tw_re !== '0 || tw_im !== '0) begin
      errors++;
      $display("FAIL reset_data: got re=%0d im=%0d, required 0,0", tw_re, tw_im);
    end
    rst = 1'b0;
    tick();
    $display("reset released");
  endtask

  task automatic run_table(input bit inv);
    int  fre [8];
    int  fim [8];
    int  n;
    bit  ok;
    word_t w;
    fre = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274};
    fim = '{0, -12540, -23170, -30274, -32767, -30274, -23170, -12540};
    for (int i = 0; i < 8; i++) begin
      w.re = fre[i]; w.im = inv ? -fim[i] : fim[i]; w.last = (i == 7);
      exp_q.push_back(w);
    end
    tw_ready = 1'b1;
    mon_en   = 1'b1;
    do_start(4, 3, inv);
    n = 1;
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL table_busy_rise: got busy=%0b err=%0b, required busy=1 err=0", busy, err);
    end
    while (tw_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL table_latency: first valid at t+%0d, required t+3", n);
    end
    drain(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL table_drain: %0d words left, busy=%0b, required 0 and 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_forward();
    run_table(1'b0);
  endtask

  task automatic test_inverse();
    run_table(1'b1);
  endtask

  task automatic test_back_to_back();
    word_t w;
    bit    ok;
    w.re = 32767; w.im = 0; w.last = 1'b1;
    exp_q.push_back(w);
    tw_ready = 1'b1;
    do_start(1, 0, 1'b0);
    tick(); tick();
    checks++;
    if (tw_valid !== 1'b1 || tw_last !== 1'b1) begin
      errors++;
      $display("FAIL s0_word: got valid=%0b last=%0b at t+3, required 1 1", tw_valid, tw_last);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL s0_busy_fall: got busy=%0b, required 0", busy);
    end
    push_model(2, 1'b1);
    do_start(3, 2, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%0b, required 1", busy);
    end
    drain(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_drain: %0d words left, required 0", exp_q.size());
    end
  endtask

  task automatic test_start_busy();
    bit ok;
    tw_ready = 1'b1;
    push_model(2, 1'b0);
    do_start(3, 2, 1'b0);
    do_start(4, 3, 1'b1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL busy_legal_start: got err=%0b, required 0", err);
    end
    do_start(0, 0, 1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL busy_illegal_start: got err=%0b, required 0", err);
    end
    drain(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busy_drain: %0d words left, busy=%0b, required 0 and 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_illegal();
    int  cases_l [3];
    int  cases_s [3];
    int  vcount;
    int  ecount;
    cases_l = '{4, 0, 11};
    cases_s = '{4, 0, 0};
    tw_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      do_start(cases_l[c], cases_s[c], 1'b0);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal_%0d_err: got err=%0b busy=%0b, required err=1 busy=0", c, err, busy);
      end
      vcount = 0;
      ecount = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (tw_valid !== 1'b0) vcount++;
        if (err !== 1'b0) ecount++;
      end
      checks++;
      if (vcount != 0 || ecount != 0) begin
        errors++;
        $display("FAIL illegal_%0d_quiet: got %0d valid and %0d err cycles, required 0 and 0", c, vcount, ecount);
      end
      $display("illegal request %0d: log2n=%0d stage=%0d", c, cases_l[c], cases_s[c]);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int stalls0;
    bit done;
    base    = words_seen;
    stalls0 = stalls_seen;
    push_model(9, 1'b0);
    tw_ready = 1'b1;
    do_start(10, 9, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      tw_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (exp_q.size() == 0 && busy === 1'b0) done = 1'b1;
    end
    tw_ready = 1'b1;
    checks++;
    if (!done || words_seen - base != 512) begin
      errors++;
      $display("FAIL bp_count: got %0d words (done=%0b), required 512", words_seen - base, done);
    end
    checks++;
    if (stalls_seen == stalls0) begin
      errors++;
      $display("FAIL bp_stalls: got 0 stalled cycles, required some");
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    tw_ready = 1'b1;
    base = words_seen;
    push_model(4, 1'b0);
    do_start(5, 4, 1'b0);
    for (int i = 0; i < 50 && (words_seen - base) < 3; i++) @(negedge clk);
    #2;
    rst = 1'b1;
    mon_en = 1'b0;
    #1;
    checks++;
    if (tw_valid !== 1'b0 || tw_last !== 1'b0 || busy !== 1'b0 || tw_re !== '0 || tw_im !== '0) begin
      errors++;
      $display("FAIL rst_async: got valid=%0b last=%0b busy=%0b re=%0d im=%0d, required all 0",
               tw_valid, tw_last, busy, tw_re, tw_im);
    end
    exp_q.delete();
    held_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    mon_en = 1'b1;
    base = words_seen;
    push_model(4, 1'b1);
    do_start(5, 4, 1'b1);
    drain(60, ok);
    checks++;
    if (!ok || words_seen - base != 16) begin
      errors++;
      $display("FAIL rst_restart: got %0d words (done=%0b), required 16", words_seen - base, ok);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_back_to_back();
    test_start_busy();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
